// File: rtl/controle_pkg.sv
// -----------------------------------------------------------------------------
// controle_pkg
// Shared constants and types for the multicycle RV32 control unit:
//   - opcode / funct3 / funct7 field values of the supported instructions
//   - ALUop encodings driven towards the ALU control
//   - state enum (values are visible on the estado debug port)
//   - instruction class enum latched in DECOD
// -----------------------------------------------------------------------------
package controle_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_HALF = 3'b001;   // lh / sh
    localparam logic [2:0] F3_AND  = 3'b111;   // andi
    localparam logic [2:0] F3_SLL  = 3'b001;   // slli
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;  // sub / sra

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_AND  = 2'b11;

    typedef enum logic [2:0] {
        ST_BUSCA = 3'd0,
        ST_DECOD = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_ESCR  = 3'd4,
        ST_FALHA = 3'd7
    } estado_t;

    // CL_NONE doubles as the reset value and the "illegal" marker.
    typedef enum logic [2:0] {
        CL_NONE  = 3'd0,
        CL_LOAD  = 3'd1,
        CL_STORE = 3'd2,
        CL_R     = 3'd3,
        CL_ANDI  = 3'd4,
        CL_SLLI  = 3'd5,
        CL_BNE   = 3'd6,
        CL_BEQ   = 3'd7
    } classe_t;

endpackage

// File: rtl/controle_multiciclo_if.sv
// -----------------------------------------------------------------------------
// controle_multiciclo_if
// Shared memory port handshake between the control unit and the memory.
//   mem_req       request (controller -> memory)
//   sinal_leitura read strobe
//   sinal_escrita write strobe
//   mem_ack       transfer complete this cycle (memory -> controller)
// master = control unit, slave = memory side.
// -----------------------------------------------------------------------------
interface controle_multiciclo_if;
    logic mem_req;
    logic sinal_leitura;
    logic sinal_escrita;
    logic mem_ack;

    modport master (
        output mem_req,
        output sinal_leitura,
        output sinal_escrita,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  sinal_leitura,
        input  sinal_escrita,
        output mem_ack
    );
endinterface

// File: rtl/controle_decod.sv
// -----------------------------------------------------------------------------
// controle_decod
// Combinational instruction classifier.
//   instr  in  32  instruction register contents
//   classe out     instruction class (CL_NONE when not supported)
//   ilegal out  1  instruction is not in the supported subset
// BRANCH_EQ = 0 makes beq decode as illegal.
// -----------------------------------------------------------------------------
module controle_decod
    import controle_pkg::*;
#(
    parameter int BRANCH_EQ = 1
) (
    input  logic [31:0] instr,
    output classe_t     classe,
    output logic        ilegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register/immediate fields do not affect classification.
    logic unused_campos;
    assign unused_campos = ^{instr[24:15], instr[11:7]};

    always_comb begin
        classe = CL_NONE;
        case (opcode)
            OP_LOAD:   if (funct3 == F3_HALF) classe = CL_LOAD;
            OP_STORE:  if (funct3 == F3_HALF) classe = CL_STORE;
            OP_R:      if (funct7 == F7_BASE || funct7 == F7_ALT) classe = CL_R;
            OP_IMM: begin
                // andi ignores funct7 (it is part of the immediate);
                // slli requires a zero upper shamt field.
                if (funct3 == F3_AND)
                    classe = CL_ANDI;
                else if (funct3 == F3_SLL && funct7 == F7_BASE)
                    classe = CL_SLLI;
            end
            OP_BRANCH: begin
                if (funct3 == F3_BNE)
                    classe = CL_BNE;
                else if (funct3 == F3_BEQ && BRANCH_EQ != 0)
                    classe = CL_BEQ;
            end
            default: ;
        endcase
    end

    assign ilegal = (classe == CL_NONE);

endmodule

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Multicycle main control unit (lh, sh, R-type, andi, slli, bne, beq).
// Sequences BUSCA -> DECOD -> EXEC -> [MEM] -> [ESCR] over a shared memory
// port with a req/ack handshake; a bounded wait counter traps a hung memory
// in the sticky FALHA state (left only through reset).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr               instruction register contents
//   zero                ALU zero flag (branch decision in EXEC)
//   mem (master)        mem_req / sinal_leitura / sinal_escrita / mem_ack
//   ir_escrita, pc_escrita, pc_src, ALUop, ALUSrc, reg_escrita, MemToReg
//                       datapath controls
//   falha               sticky fault indication
//   estado              current state (debug)
// ir_escrita / pc_escrita / pc_src react to mem_ack / zero in the same cycle;
// everything else depends only on state and latched class.
// -----------------------------------------------------------------------------
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15,
    parameter int BRANCH_EQ    = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 instr,
    input  logic                        zero,
    controle_multiciclo_if.master       mem,
    output logic                        ir_escrita,
    output logic                        pc_escrita,
    output logic                        pc_src,
    output logic [1:0]                  ALUop,
    output logic                        ALUSrc,
    output logic                        reg_escrita,
    output logic                        MemToReg,
    output logic                        falha,
    output logic [2:0]                  estado
);

    localparam int            CW       = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] WAIT_LIM = CW'(MEM_WAIT_MAX);

    estado_t       state_q, state_d;
    classe_t       class_q, class_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    classe_t dec_classe;
    logic    dec_ilegal;
    logic    mem_ack;
    logic    desvio_tomado;

    assign mem_ack = mem.mem_ack;

    controle_decod #(
        .BRANCH_EQ (BRANCH_EQ)
    ) u_decod (
        .instr  (instr),
        .classe (dec_classe),
        .ilegal (dec_ilegal)
    );

    assign desvio_tomado = (class_q == CL_BNE && !zero) ||
                           (class_q == CL_BEQ &&  zero);

    // Next state / class / wait counter.
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BUSCA: begin
                // An ack on the limit cycle still completes the fetch.
                if (mem_ack)
                    state_d = ST_DECOD;
                else if (cnt_q == WAIT_LIM)
                    state_d = ST_FALHA;
                else
                    cnt_d = cnt_q + CW'(1);
            end
            ST_DECOD: begin
                class_d = dec_classe;
                state_d = dec_ilegal ? ST_FALHA : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CL_LOAD, CL_STORE: begin
                        state_d = ST_MEM;
                        cnt_d   = '0;
                    end
                    CL_R, CL_ANDI, CL_SLLI: state_d = ST_ESCR;
                    CL_BNE, CL_BEQ: begin
                        state_d = ST_BUSCA;
                        cnt_d   = '0;
                    end
                    default: state_d = ST_FALHA;
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (class_q == CL_LOAD) begin
                        state_d = ST_ESCR;
                    end else begin
                        state_d = ST_BUSCA;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == WAIT_LIM) begin
                    state_d = ST_FALHA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_ESCR: begin
                state_d = ST_BUSCA;
                cnt_d   = '0;
            end
            ST_FALHA: state_d = ST_FALHA;
            default:  state_d = ST_FALHA;   // unused encodings 5/6
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BUSCA;
            class_q <= CL_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode; reset masks everything during the reset cycle so an
    // in-flight access is aborted without a stray strobe.
    always_comb begin
        mem.mem_req       = 1'b0;
        mem.sinal_leitura = 1'b0;
        mem.sinal_escrita = 1'b0;
        ir_escrita        = 1'b0;
        pc_escrita        = 1'b0;
        pc_src            = 1'b0;
        ALUop             = ALU_ADD;
        ALUSrc            = 1'b0;
        reg_escrita       = 1'b0;
        MemToReg          = 1'b0;
        falha             = 1'b0;
        estado            = 3'd0;
        if (!reset) begin
            estado = state_q;
            case (state_q)
                ST_BUSCA: begin
                    mem.mem_req       = 1'b1;
                    mem.sinal_leitura = 1'b1;
                    ir_escrita        = mem_ack;
                    pc_escrita        = mem_ack;
                end
                ST_EXEC: begin
                    case (class_q)
                        CL_LOAD, CL_STORE: begin
                            ALUop  = ALU_ADD;
                            ALUSrc = 1'b1;
                        end
                        CL_R:    ALUop = ALU_FUNC;
                        CL_ANDI: begin
                            ALUop  = ALU_AND;
                            ALUSrc = 1'b1;
                        end
                        CL_SLLI: begin
                            ALUop  = ALU_FUNC;
                            ALUSrc = 1'b1;
                        end
                        CL_BNE, CL_BEQ: begin
                            ALUop      = ALU_SUB;
                            pc_escrita = desvio_tomado;
                            pc_src     = desvio_tomado;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    mem.mem_req       = 1'b1;
                    mem.sinal_leitura = (class_q == CL_LOAD);
                    mem.sinal_escrita = (class_q == CL_STORE);
                    ALUop             = ALU_ADD;
                    ALUSrc            = 1'b1;
                end
                ST_ESCR: begin
                    reg_escrita = 1'b1;
                    MemToReg    = (class_q == CL_LOAD);
                end
                ST_FALHA: falha = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Two instances share all stimulus: dut1 decodes beq, dut0 treats it as
// illegal. Expected per-cycle output vectors are generated up front from
// per-instruction phase lists (fetch, decode, execute, memory, write-back)
// and checked every cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;

    localparam int MAXW = 15;

    typedef struct packed {
        logic       mem_req;
        logic       rd;
        logic       wr;
        logic       ir;
        logic       pcw;
        logic       pcsrc;
        logic [1:0] aluop;
        logic       alusrc;
        logic       regw;
        logic       m2r;
        logic       falha;
        logic [2:0] estado;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        ack;
        logic        z;
        logic [31:0] ins;
    } stim_t;

    localparam int K_ILL = 0, K_LOAD = 1, K_STORE = 2, K_R = 3, K_ANDI = 4,
                   K_SLLI = 5, K_BNE = 6, K_BEQ = 7;

    logic        clk = 1'b0;
    logic        rst_tb = 1'b1;
    logic        ack_tb = 1'b0;
    logic        zero_tb = 1'b0;
    logic [31:0] instr_tb = 32'h0;

    always #5 clk = ~clk;

    controle_multiciclo_if m1 ();
    controle_multiciclo_if m0 ();
    assign m1.mem_ack = ack_tb;
    assign m0.mem_ack = ack_tb;

    logic       ir1, pcw1, pcs1, src1, rw1, m2r1, f1;
    logic       ir0, pcw0, pcs0, src0, rw0, m2r0, f0;
    logic [1:0] alu1, alu0;
    logic [2:0] est1, est0;

    controle_multiciclo #(.MEM_WAIT_MAX(MAXW), .BRANCH_EQ(1)) dut1 (
        .clk(clk), .reset(rst_tb), .instr(instr_tb), .zero(zero_tb), .mem(m1),
        .ir_escrita(ir1), .pc_escrita(pcw1), .pc_src(pcs1), .ALUop(alu1),
        .ALUSrc(src1), .reg_escrita(rw1), .MemToReg(m2r1), .falha(f1), .estado(est1)
    );

    controle_multiciclo #(.MEM_WAIT_MAX(MAXW), .BRANCH_EQ(0)) dut0 (
        .clk(clk), .reset(rst_tb), .instr(instr_tb), .zero(zero_tb), .mem(m0),
        .ir_escrita(ir0), .pc_escrita(pcw0), .pc_src(pcs0), .ALUop(alu0),
        .ALUSrc(src0), .reg_escrita(rw0), .MemToReg(m2r0), .falha(f0), .estado(est0)
    );

    out_t got1, got0;
    assign got1 = {m1.mem_req, m1.sinal_leitura, m1.sinal_escrita, ir1, pcw1, pcs1,
                   alu1, src1, rw1, m2r1, f1, est1};
    assign got0 = {m0.mem_req, m0.sinal_leitura, m0.sinal_escrita, ir0, pcw0, pcs0,
                   alu0, src0, rw0, m2r0, f0, est0};

    stim_t stim_q[$];
    out_t  exp1_q[$];
    out_t  exp0_q[$];
    out_t  lit_val[int];
    int    n_vec = 0;
    int    n_bad = 0;
    int    cur = -1;
    bit    nb_faulted = 0;
    bit    last_fault = 0;
    int    plan_start = 0;
    int    plan_len = 0;

    function automatic out_t blank(input int est);
        out_t o;
        o = '0;
        o.estado = 3'(est);
        return o;
    endfunction

    function automatic out_t falha_vec();
        out_t o;
        o = blank(7);
        o.falha = 1'b1;
        return o;
    endfunction

    function automatic int classify(input logic [31:0] ins, input bit beq_en);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        if (op == 7'b0000011 && f3 == 3'b001) return K_LOAD;
        if (op == 7'b0100011 && f3 == 3'b001) return K_STORE;
        if (op == 7'b0110011 && (f7 == 7'b0000000 || f7 == 7'b0100000)) return K_R;
        if (op == 7'b0010011 && f3 == 3'b111) return K_ANDI;
        if (op == 7'b0010011 && f3 == 3'b001 && f7 == 7'b0) return K_SLLI;
        if (op == 7'b1100011 && f3 == 3'b001) return K_BNE;
        if (op == 7'b1100011 && f3 == 3'b000 && beq_en) return K_BEQ;
        return K_ILL;
    endfunction

    task automatic check(input string name, input int cyc, input out_t got, input out_t exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b required=%b", name, cyc, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // sel=1 also records the shared stimulus; sel=0 only the dut0 expectation.
    task automatic emit(input int sel, input out_t o, input logic ack, input logic z,
                        input logic [31:0] ins);
        stim_t s;
        if (sel == 1) begin
            exp1_q.push_back(o);
            s = {1'b0, ack, z, ins};
            stim_q.push_back(s);
        end else begin
            exp0_q.push_back(o);
        end
    endtask

    task automatic fault(input int sel, input int tail, input logic z, input logic [31:0] ins);
        last_fault = 1;
        repeat (tail) emit(sel, falha_vec(), 1'b1, z, ins);
    endtask

    // fw / mw: cycles without ack before the ack in fetch / memory phase.
    // ack is held high on every non-memory cycle; it must be ignored there.
    task automatic gen(input int sel, input logic [31:0] ins, input int fw, input int mw,
                       input logic z, input int tail);
        out_t o;
        int   k;
        logic taken;
        last_fault = 0;
        o = blank(0);
        o.mem_req = 1'b1;
        o.rd = 1'b1;
        for (int i = 0; i < fw && i <= MAXW; i++) emit(sel, o, 1'b0, z, ins);
        if (fw > MAXW) begin
            fault(sel, tail, z, ins);
            return;
        end
        o.ir = 1'b1;
        o.pcw = 1'b1;
        emit(sel, o, 1'b1, z, ins);
        emit(sel, blank(1), 1'b1, z, ins);
        k = classify(ins, sel == 1);
        if (k == K_ILL) begin
            fault(sel, tail, z, ins);
            return;
        end
        o = blank(2);
        case (k)
            K_LOAD, K_STORE: o.alusrc = 1'b1;
            K_R:             o.aluop = 2'b10;
            K_ANDI: begin o.aluop = 2'b11; o.alusrc = 1'b1; end
            K_SLLI: begin o.aluop = 2'b10; o.alusrc = 1'b1; end
            default: begin
                o.aluop = 2'b01;
                taken = (k == K_BNE) ? !z : z;
                o.pcw = taken;
                o.pcsrc = taken;
            end
        endcase
        emit(sel, o, 1'b1, z, ins);
        if (k == K_LOAD || k == K_STORE) begin
            o = blank(3);
            o.mem_req = 1'b1;
            o.rd = (k == K_LOAD);
            o.wr = (k == K_STORE);
            o.alusrc = 1'b1;
            for (int i = 0; i < mw && i <= MAXW; i++) emit(sel, o, 1'b0, z, ins);
            if (mw > MAXW) begin
                fault(sel, tail, z, ins);
                return;
            end
            emit(sel, o, 1'b1, z, ins);
        end
        if (k == K_LOAD || k == K_R || k == K_ANDI || k == K_SLLI) begin
            o = blank(4);
            o.regw = 1'b1;
            o.m2r = (k == K_LOAD);
            emit(sel, o, 1'b1, z, ins);
        end
    endtask

    // cut >= 0 truncates the instruction after that many cycles (for a reset abort).
    task automatic plan(input logic [31:0] ins, input int fw, input int mw, input logic z,
                        input int tail, input int cut);
        int s;
        s = exp1_q.size();
        gen(1, ins, fw, mw, z, tail);
        if (cut >= 0)
            while (exp1_q.size() > s + cut) begin
                void'(exp1_q.pop_back());
                void'(stim_q.pop_back());
            end
        if (!nb_faulted) begin
            gen(0, ins, fw, mw, z, 0);
            if (last_fault) nb_faulted = 1;
        end
        while (exp0_q.size() > exp1_q.size()) void'(exp0_q.pop_back());
        while (exp0_q.size() < exp1_q.size()) exp0_q.push_back(falha_vec());
        plan_start = s;
        plan_len = exp1_q.size() - s;
    endtask

    task automatic plan_reset(input int n);
        stim_t s;
        s = {1'b1, 1'b1, 1'b1, 32'h0};
        repeat (n) begin
            stim_q.push_back(s);
            exp1_q.push_back(blank(0));
            exp0_q.push_back(blank(0));
        end
        nb_faulted = 0;
    endtask

    always @(negedge clk) begin
        if (cur >= 0) begin
            check("dut1", cur, got1, exp1_q[cur]);
            check("dut0_nobeq", cur, got0, exp0_q[cur]);
            if (lit_val.exists(cur)) check("literal", cur, got1, lit_val[cur]);
        end
    end

    initial begin
        plan_reset(2);

        plan(32'h002081B3, 0, 0, 1'b0, 0, -1);                 // add
        check_int("len_add", plan_len, 4);
        lit_val[plan_start + 0] = 15'b1_1_0_1_1_0_00_0_0_0_0_000;
        lit_val[plan_start + 2] = 15'b0_0_0_0_0_0_10_0_0_0_0_010;
        lit_val[plan_start + 3] = 15'b0_0_0_0_0_0_00_0_1_0_0_100;

        plan(32'h00409183, 1, 3, 1'b0, 0, -1);                 // lh, waits
        check_int("len_lh_w1_w3", plan_len, 9);
        lit_val[plan_start + 4] = 15'b1_1_0_0_0_0_00_1_0_0_0_011;
        lit_val[plan_start + 8] = 15'b0_0_0_0_0_0_00_0_1_1_0_100;

        plan(32'h00209063, 0, 0, 1'b0, 0, -1);                 // bne taken
        check_int("len_bne_taken", plan_len, 3);
        lit_val[plan_start + 2] = 15'b0_0_0_0_1_1_01_0_0_0_0_010;
        plan(32'h00209063, 0, 0, 1'b1, 0, -1);                 // bne not taken
        check_int("len_bne_not", plan_len, 3);
        lit_val[plan_start + 2] = 15'b0_0_0_0_0_0_01_0_0_0_0_010;

        plan(32'h0FF0F193, 0, 0, 1'b0, 0, -1);                 // andi
        plan(32'h00209193, 0, 0, 1'b0, 0, -1);                 // slli
        plan(32'h402081B3, 0, 0, 1'b1, 0, -1);                 // sub
        plan(32'h00209223, 0, 2, 1'b0, 0, -1);                 // sh
        check_int("len_sh_w2", plan_len, 6);

        plan(32'h00208063, 0, 0, 1'b1, 0, -1);                 // beq: dut0 faults
        plan(32'h002081B3, 0, 0, 1'b0, 0, -1);                 // dut0 stays faulted
        plan_reset(1);
        plan(32'h00208063, 2, 0, 1'b0, 0, -1);                 // beq not taken

        plan(32'h002081B3, MAXW, 0, 1'b0, 0, -1);              // ack on last wait cycle
        check_int("len_add_w15", plan_len, 4 + MAXW);
        plan(32'h00409183, 0, MAXW, 1'b1, 0, -1);              // lh, mem ack at limit

        plan(32'h002081B3, MAXW + 1, 0, 1'b0, 4, -1);          // fetch timeout
        lit_val[plan_start + MAXW + 1] = 15'b0_0_0_0_0_0_00_0_0_0_1_111;
        plan_reset(1);

        plan(32'h00000013, 0, 0, 1'b0, 3, -1);                 // addi: illegal
        plan_reset(1);
        plan(32'h022081B3, 1, 0, 1'b0, 2, -1);                 // bad funct7: illegal
        plan_reset(1);

        plan(32'h00209223, 0, 5, 1'b0, 0, 3);                  // sh, reset during MEM
        plan_reset(1);
        lit_val[plan_start + 3] = 15'b0;
        plan(32'h002081B3, 0, 0, 1'b0, 0, -1);
        lit_val[plan_start + 0] = 15'b1_1_0_1_1_0_00_0_0_0_0_000;

        plan(32'h00209223, 0, MAXW + 1, 1'b0, 2, -1);          // mem timeout
        plan_reset(1);
        plan(32'h00409183, 0, 0, 1'b0, 0, -1);                 // lh, no waits
        check_int("len_lh", plan_len, 5);

        for (int c = 0; c < stim_q.size(); c++) begin
            @(posedge clk);
            #1;
            rst_tb   = stim_q[c].rst;
            ack_tb   = stim_q[c].ack;
            zero_tb  = stim_q[c].z;
            instr_tb = stim_q[c].ins;
            cur      = c;
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
